// File: rtl/reg_write_arbiter_pkg.sv
// Shared constants and types for the register-file write arbiter.
// Holds default widths, the hard-wired zero register index and the requester id enum.
package reg_write_arbiter_pkg;

    localparam int WORD_LEN_DEFAULT  = 32;
    localparam int ADDR_BITS_DEFAULT = 5;
    localparam int ZERO_REG          = 0;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } reqId_t;

endpackage

// File: rtl/reg_write_arbiter_rr_arbiter2.sv
// Two-way round-robin grant select: purely combinational, one-hot or zero output.
// A lone requester always wins; on contention the side not granted last time wins.
module rr_arbiter2
    import reg_write_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  reqId_t     lastGnt,
    input  logic       hold,
    output logic [1:0] gnt
);

    always_comb begin
        // NOTE: default assigned first so no path leaves gnt unassigned, which would infer a latch.
        gnt = 2'b00;
        if (!hold) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (lastGnt == REQ0) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates two register-file write requesters onto one registered write port.
// Optional read-after-write forwarding is enabled with macro REG_WRITE_ARBITER_FWD_EN.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int WordLen  = WORD_LEN_DEFAULT,
    parameter int AddrBits = ADDR_BITS_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hold,
    input  logic                req0,
    input  logic                req1,
    input  logic [AddrBits-1:0] addr0,
    input  logic [AddrBits-1:0] addr1,
    input  logic [WordLen-1:0]  data0,
    input  logic [WordLen-1:0]  data1,
`ifdef REG_WRITE_ARBITER_FWD_EN
    input  logic [AddrBits-1:0] rdAddr1,
    input  logic [AddrBits-1:0] rdAddr2,
    input  logic [WordLen-1:0]  rfData1,
    input  logic [WordLen-1:0]  rfData2,
    output logic [WordLen-1:0]  fwdData1,
    output logic [WordLen-1:0]  fwdData2,
`endif
    output logic                gnt0,
    output logic                gnt1,
    output logic                regWrite,
    output logic [AddrBits-1:0] writeRegister,
    output logic [WordLen-1:0]  writeData
);

    localparam logic [AddrBits-1:0] ZeroIdx = AddrBits'(ZERO_REG);

    logic [1:0] gnt;
    reqId_t     lastGnt;

    // Reset suppresses grants so nothing is accepted during the reset cycle.
    rr_arbiter2 u_rrArbiter2 (
        .req     ({req1, req0}),
        .lastGnt (lastGnt),
        .hold    (hold | rst),
        .gnt     (gnt)
    );

    assign gnt0 = gnt[0];
    assign gnt1 = gnt[1];

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            regWrite      <= 1'b0;
            writeRegister <= '0;
            writeData     <= '0;
            lastGnt       <= REQ1;
        end else begin
            regWrite <= 1'b0;
            if (gnt[0]) begin
                regWrite      <= (addr0 != ZeroIdx);
                writeRegister <= addr0;
                writeData     <= data0;
                lastGnt       <= REQ0;
            end else if (gnt[1]) begin
                regWrite      <= (addr1 != ZeroIdx);
                writeRegister <= addr1;
                writeData     <= data1;
                lastGnt       <= REQ1;
            end
        end
    end

`ifdef REG_WRITE_ARBITER_FWD_EN
    // Bypass the write in flight so a same-cycle read sees it; register 0 is never forwarded.
    assign fwdData1 = (regWrite && (rdAddr1 == writeRegister) && (rdAddr1 != ZeroIdx))
                      ? writeData : rfData1;
    assign fwdData2 = (regWrite && (rdAddr2 == writeRegister) && (rdAddr2 != ZeroIdx))
                      ? writeData : rfData2;
`endif

endmodule
